// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I subset core.
// Sequences fetch, decode, execute, memory access and writeback, stalls on the
// memory ready handshake and abandons an access that waits too long.
//
// Memory handshake: in FETCH, MEM_READ and MEM_WRITE the request strobe
// (oMemRead / oMemWrite) is held for as long as the state lasts. The access
// completes in the cycle iMemReady is sampled high, and the FSM leaves the
// state at the next rising edge. iMemReady is ignored in every other state.

module multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [6:0] iOpcode,
    input  logic       iZero,
    input  logic       iMemReady,
    output logic       oPCWrite,
    output logic       oPCWriteCond,
    output logic       oIorD,
    output logic       oMemRead,
    output logic       oMemWrite,
    output logic       oIRWrite,
    output logic       oMemtoReg,
    output logic       oRegWrite,
    output logic       oALUSrcA,
    output logic [1:0] oALUSrcB,
    output logic [1:0] oALUOp,
    output logic [1:0] oPCSource,
    output logic       oIllegal,
    output logic       oBusErr,
    output logic [3:0] oState
);

    // State codes are visible on oState, so they are fixed explicitly.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JAL       = 4'd9,
        S_ALU_WB    = 4'd10
    } state_t;

    // Supported major opcodes.
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // ALU control selector encodings.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_ANY = 2'b10;

    // Operand B select encodings.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // PC source encodings.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // The counter only has to reach WAIT_LIMIT-1; keep at least one bit so a
    // disabled timeout still elaborates cleanly.
    localparam int         CW         = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam bit         TIMEOUT_EN = (WAIT_LIMIT != 0);
    localparam logic [CW-1:0] LIMIT_M1 = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t          r_state;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_illegal;
    logic            r_bus_err;

    state_t          w_next_state;
    logic            w_in_wait;
    logic            w_timeout;
    logic            w_decode_illegal;
    logic            w_unused_zero;

    // iZero gates oPCWriteCond in the datapath; the FSM itself never needs it.
    assign w_unused_zero = iZero;

    // A wait state is any state that holds a memory request open.
    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                       (r_state == S_MEM_WRITE);

    // Timeout fires on the WAIT_LIMIT-th consecutive not-ready cycle; a ready
    // in that same cycle wins and lets the access complete.
    assign w_timeout = TIMEOUT_EN && w_in_wait && !iMemReady &&
                       (r_wait_cnt == LIMIT_M1);

    // Decode-time classification of unsupported opcodes.
    always_comb begin
        w_decode_illegal = 1'b1;
        case (iOpcode)
            OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL:
                w_decode_illegal = 1'b0;
            default:
                w_decode_illegal = 1'b1;
        endcase
    end

    // Next-state selection.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: begin
                if (iMemReady)      w_next_state = S_DECODE;
                else                w_next_state = S_FETCH;
            end
            S_DECODE: begin
                case (iOpcode)
                    OPC_RTYPE:             w_next_state = S_EXEC_R;
                    OPC_ITYPE:             w_next_state = S_EXEC_I;
                    OPC_LOAD, OPC_STORE:   w_next_state = S_MEM_ADDR;
                    OPC_BRANCH:            w_next_state = S_BRANCH;
                    OPC_JAL:               w_next_state = S_JAL;
                    default:               w_next_state = S_FETCH;
                endcase
            end
            S_EXEC_R:       w_next_state = S_ALU_WB;
            S_EXEC_I:       w_next_state = S_ALU_WB;
            // The instruction register still holds the opcode, so it picks
            // between the read and write paths here.
            S_MEM_ADDR: begin
                if (iOpcode == OPC_STORE) w_next_state = S_MEM_WRITE;
                else                      w_next_state = S_MEM_READ;
            end
            S_MEM_READ: begin
                if (iMemReady)      w_next_state = S_MEM_WB;
                else if (w_timeout) w_next_state = S_FETCH;
                else                w_next_state = S_MEM_READ;
            end
            S_MEM_WB:       w_next_state = S_FETCH;
            S_MEM_WRITE: begin
                if (iMemReady)      w_next_state = S_FETCH;
                else                w_next_state = S_MEM_WRITE;
                if (!iMemReady && w_timeout) w_next_state = S_FETCH;
            end
            S_BRANCH:       w_next_state = S_FETCH;
            S_JAL:          w_next_state = S_FETCH;
            S_ALU_WB:       w_next_state = S_FETCH;
            default:        w_next_state = S_FETCH;
        endcase
    end

    // State register, wait counter and the two registered event pulses.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_illegal <= (r_state == S_DECODE) && w_decode_illegal;
            r_bus_err <= w_timeout;
            // Outside wait states the count is always zero, which is what
            // makes every entry into a wait state start from a clean count.
            // With the timeout disabled the count saturates instead of wrapping.
            if (w_in_wait && !iMemReady && !w_timeout) begin
                if (r_wait_cnt != CNT_MAX)
                    r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Moore decode of the datapath controls; only the FETCH completion
    // controls additionally look at the ready handshake.
    always_comb begin
        oPCWrite     = 1'b0;
        oPCWriteCond = 1'b0;
        oIorD        = 1'b0;
        oMemRead     = 1'b0;
        oMemWrite    = 1'b0;
        oIRWrite     = 1'b0;
        oMemtoReg    = 1'b0;
        oRegWrite    = 1'b0;
        oALUSrcA     = 1'b0;
        oALUSrcB     = SRCB_RS2;
        oALUOp       = ALU_ADD;
        oPCSource    = PCSRC_ALU;
        case (r_state)
            S_FETCH: begin
                oMemRead = 1'b1;
                oIorD    = 1'b0;
                if (iMemReady) begin
                    oIRWrite  = 1'b1;
                    oPCWrite  = 1'b1;
                    oALUSrcA  = 1'b0;
                    oALUSrcB  = SRCB_FOUR;
                    oALUOp    = ALU_ADD;
                    oPCSource = PCSRC_ALU;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                oALUSrcA = 1'b0;
                oALUSrcB = SRCB_IMM;
                oALUOp   = ALU_ADD;
            end
            S_EXEC_R: begin
                oALUSrcA = 1'b1;
                oALUSrcB = SRCB_RS2;
                oALUOp   = ALU_ANY;
            end
            S_EXEC_I: begin
                oALUSrcA = 1'b1;
                oALUSrcB = SRCB_IMM;
                oALUOp   = ALU_ANY;
            end
            S_MEM_ADDR: begin
                oALUSrcA = 1'b1;
                oALUSrcB = SRCB_IMM;
                oALUOp   = ALU_ADD;
            end
            S_MEM_READ: begin
                oMemRead = 1'b1;
                oIorD    = 1'b1;
            end
            S_MEM_WB: begin
                oRegWrite = 1'b1;
                oMemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                oMemWrite = 1'b1;
                oIorD     = 1'b1;
            end
            S_BRANCH: begin
                oALUSrcA     = 1'b1;
                oALUSrcB     = SRCB_RS2;
                oALUOp       = ALU_SUB;
                oPCWriteCond = 1'b1;
                oPCSource    = PCSRC_ALUOUT;
            end
            S_JAL: begin
                oPCWrite  = 1'b1;
                oPCSource = PCSRC_JUMP;
                oRegWrite = 1'b1;
                oMemtoReg = 1'b0;
            end
            S_ALU_WB: begin
                oRegWrite = 1'b1;
                oMemtoReg = 1'b0;
            end
            default: begin
                // Unused codes drive nothing and fall back to FETCH.
            end
        endcase
    end

    assign oIllegal = r_illegal;
    assign oBusErr  = r_bus_err;
    assign oState   = r_state;

endmodule
